// File: rtl/layernorm_stats_seq_if.sv
// Streaming ports of the LayerNorm row-statistics block: element input and per-row result output.
// Handshake: a beat transfers on a rising edge where valid && ready; valid never waits on ready, and a raised valid holds its payload unchanged until that transfer.
interface layernorm_stats_seq_if #(
  parameter int WIDTH        = 8,
  parameter int RESULT_WIDTH = 18,
  parameter int ROW_W        = 2
);
  logic [WIDTH-1:0]        in_data;
  logic                    in_valid;
  logic                    in_ready;
  logic [RESULT_WIDTH-1:0] out_avg;
  logic [RESULT_WIDTH-1:0] out_stddev;
  logic [ROW_W-1:0]        out_row;
  logic                    out_last;
  logic                    out_valid;
  logic                    out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_avg, out_stddev, out_row, out_last, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_avg, out_stddev, out_row, out_last, out_valid
  );
endinterface

// File: rtl/layernorm_stats_seq.sv
// Row-serial LayerNorm statistics: accumulates sum / sum of squares per row, then emits the
// fixed-point mean and the population stddev from a shared restoring bit-serial square root.
module layernorm_stats_seq #(
  parameter int M              = 4,
  parameter int N              = 4,
  parameter int WIDTH          = 8,
  parameter int FRACTION_WIDTH = 8,
  parameter int RESULT_WIDTH   = WIDTH + $clog2(N) + FRACTION_WIDTH,
  parameter int ROW_W          = (M > 1) ? $clog2(M) : 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic [2:0] fsm_state,
  layernorm_stats_seq_if.slave bus
);
  localparam int LOGN  = $clog2(N);
  localparam int F     = FRACTION_WIDTH;
  localparam int Q     = WIDTH + F;
  localparam int RAD_W = 2 * Q;
  localparam int REM_W = Q + 1;
  localparam int SUM_W = WIDTH + LOGN;
  localparam int SQ_W  = 2 * WIDTH + LOGN;
  localparam int VAR_W = 2 * Q + 2 * LOGN;
  localparam int COL_W = LOGN;
  localparam int CNT_W = $clog2(Q + 1);

  if (N < 2 || (1 << LOGN) != N) begin : g_bad_n
    $error("layernorm_stats_seq: N must be a power of two >= 2");
  end
  if (M < 1) begin : g_bad_m
    $error("layernorm_stats_seq: M must be >= 1");
  end

  typedef enum logic [2:0] {IDLE, ACCUM, CALC, SQRT, OUT} state_t;

  state_t state, state_nx;

  logic [ROW_W-1:0]        row;
  logic [COL_W-1:0]        col;
  logic [SUM_W-1:0]        sum;
  logic [SQ_W-1:0]         sumsq;
  logic [RESULT_WIDTH-1:0] avg_q;
  logic [RAD_W-1:0]        rad;
  logic [REM_W-1:0]        rem;
  logic [Q-1:0]            root;
  logic [CNT_W-1:0]        cnt;

  logic                    take;
  logic                    last_row;
  logic                    start_ok;
  logic [2*WIDTH-1:0]      x_ext;
  logic [2*WIDTH-1:0]      sq;
  logic [VAR_W-1:0]        num;
  logic [RAD_W-1:0]        rad_load;
  logic [RESULT_WIDTH-1:0] avg_calc;
  logic [REM_W+1:0]        rem_sh;
  logic [REM_W+1:0]        trial;
  logic                    ge;

  assign take     = (state == ACCUM) && bus.in_valid;
  assign last_row = (row == ROW_W'(M - 1));
  // done is high only in the IDLE cycle right after a frame; a start there is dropped.
  assign start_ok = start && !done;

  assign x_ext = {{WIDTH{1'b0}}, bus.in_data};
  assign sq    = x_ext * x_ext;

  // N*sumsq >= sum*sum always, so the subtraction cannot wrap.
  assign num      = VAR_W'(N) * VAR_W'(sumsq) - VAR_W'(sum) * VAR_W'(sum);
  assign rad_load = RAD_W'((num << (2 * F)) >> (2 * LOGN));
  assign avg_calc = (RESULT_WIDTH'(sum) << F) >> LOGN;

  // One restoring step: bring down two radicand bits, try subtracting 4*root+1.
  assign rem_sh = {rem, rad[RAD_W-1 -: 2]};
  assign trial  = {1'b0, root, 2'b01};
  assign ge     = (rem_sh >= trial);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start_ok) state_nx = ACCUM;
      ACCUM:   if (take && col == COL_W'(N - 1)) state_nx = CALC;
      CALC:    state_nx = SQRT;
      SQRT:    if (cnt == CNT_W'(Q - 1)) state_nx = OUT;
      OUT:     if (bus.out_ready) state_nx = last_row ? IDLE : ACCUM;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row   <= '0;
      col   <= '0;
      sum   <= '0;
      sumsq <= '0;
      avg_q <= '0;
      rad   <= '0;
      rem   <= '0;
      root  <= '0;
      cnt   <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start_ok) begin
            row   <= '0;
            col   <= '0;
            sum   <= '0;
            sumsq <= '0;
          end
        end
        ACCUM: begin
          if (take) begin
            sum   <= sum + SUM_W'(bus.in_data);
            sumsq <= sumsq + SQ_W'(sq);
            col   <= (col == COL_W'(N - 1)) ? '0 : col + COL_W'(1);
          end
        end
        CALC: begin
          avg_q <= avg_calc;
          rad   <= rad_load;
          rem   <= '0;
          root  <= '0;
          cnt   <= '0;
        end
        SQRT: begin
          rad  <= rad << 2;
          rem  <= ge ? REM_W'(rem_sh - trial) : REM_W'(rem_sh);
          root <= (root << 1) | Q'(ge);
          cnt  <= cnt + CNT_W'(1);
        end
        OUT: begin
          if (bus.out_ready) begin
            if (last_row) begin
              done <= 1'b1;
            end else begin
              row   <= row + ROW_W'(1);
              sum   <= '0;
              sumsq <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign busy           = (state != IDLE);
  assign fsm_state      = state;
  assign bus.in_ready   = (state == ACCUM);
  assign bus.out_valid  = (state == OUT);
  assign bus.out_last   = (state == OUT) && last_row;
  assign bus.out_avg    = avg_q;
  assign bus.out_stddev = RESULT_WIDTH'(root);
  assign bus.out_row    = row;
endmodule

// File: tb/tb_layernorm_stats_seq.sv
// Bench for layernorm_stats_seq: an M=4 instance for frame scenarios and an M=1 instance
// for the single-row latency case, both checked against an arithmetic reference model.
module tb_layernorm_stats_seq;
  localparam int WIDTH = 8;
  localparam int F     = 8;
  localparam int N     = 4;
  localparam int RW    = WIDTH + 2 + F;
  localparam int EW    = 2 * RW + 3;

  logic clk = 1'b0;
  logic rst;
  logic start4, busy4, done4;
  logic start1, busy1, done1;
  logic [2:0] st4, st1;

  int vectors = 0;
  int miscompares = 0;
  int done_cnt4 = 0;
  logic [EW-1:0] exp_q[$];

  always #5 clk = ~clk;

  layernorm_stats_seq_if #(.WIDTH(WIDTH), .RESULT_WIDTH(RW), .ROW_W(2)) b4 ();
  layernorm_stats_seq_if #(.WIDTH(WIDTH), .RESULT_WIDTH(RW), .ROW_W(1)) b1 ();

  layernorm_stats_seq #(.M(4), .N(N), .WIDTH(WIDTH), .FRACTION_WIDTH(F)) u_dut4 (
    .clk(clk), .rst(rst), .start(start4), .busy(busy4), .done(done4),
    .fsm_state(st4), .bus(b4.slave)
  );

  layernorm_stats_seq #(.M(1), .N(N), .WIDTH(WIDTH), .FRACTION_WIDTH(F)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .busy(busy1), .done(done1),
    .fsm_state(st1), .bus(b1.slave)
  );

  always @(negedge clk) if (done4 === 1'b1) done_cnt4++;

  // Reference: mean = sum*2^F/N, var = (N*sumsq - sum^2)*2^2F/N^2, stddev = floor(sqrt(var)).
  function automatic logic [EW-1:0] pack_exp(input int v[4], input int row, input bit last);
    longint s = 0, q = 0, vq, avg, sd = 0, t;
    foreach (v[i]) begin
      s += v[i];
      q += longint'(v[i]) * v[i];
    end
    avg = s * (longint'(1) << F) / N;
    vq  = (N * q - s * s) * (longint'(1) << (2 * F)) / (N * N);
    for (int b = 17; b >= 0; b--) begin
      t = sd | (longint'(1) << b);
      if (t * t <= vq) sd = t;
    end
    return {RW'(avg), RW'(sd), 2'(row), last};
  endfunction

  task automatic pulse_start4;
    @(negedge clk); start4 = 1'b1;
    @(negedge clk); start4 = 1'b0;
  endtask

  // Called on a negedge; returns on the negedge after the last element is accepted.
  task automatic drive_row4(input int v[4], input int mode, output bit ok);
    int i = 0, g = 0;
    bit ph = 1'b1;
    ok = 1'b1;
    while (i < N) begin
      case (mode)
        0:       b4.in_valid = 1'b1;
        1:       begin b4.in_valid = ph; ph = !ph; end
        default: b4.in_valid = 1'($urandom_range(0, 1));
      endcase
      b4.in_data = WIDTH'(v[i]);
      #1;
      if (b4.in_valid && b4.in_ready) i++;
      @(negedge clk);
      g++;
      if (g > 200) begin ok = 1'b0; break; end
    end
    b4.in_valid = 1'b0;
  endtask

  task automatic wait_out4(output bit ok);
    int g = 0;
    ok = 1'b1;
    while (b4.out_valid !== 1'b1) begin
      @(negedge clk);
      g++;
      if (g > 100) begin ok = 1'b0; break; end
    end
  endtask

  function automatic void rand_row(output int v[4]);
    foreach (v[i]) v[i] = ($urandom_range(0, 7) == 0) ? 255 : int'($urandom_range(0, 255));
  endfunction

  task automatic test_reset;
    rst = 1'b1; start4 = 1'b0; start1 = 1'b0;
    b4.in_valid = 1'b0; b4.in_data = '0; b4.out_ready = 1'b1;
    b1.in_valid = 1'b0; b1.in_data = '0; b1.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if ({busy4, done4, b4.in_ready, b4.out_valid, b4.out_last, b4.out_row, st4} !== 10'b0) begin
      miscompares++;
      $display("FAIL reset_ctl4: got %b expected 0", {busy4, done4, b4.in_ready, b4.out_valid, b4.out_last, b4.out_row, st4});
    end
    vectors++;
    if ({b4.out_avg, b4.out_stddev} !== '0) begin
      miscompares++;
      $display("FAIL reset_data4: got %h expected 0", {b4.out_avg, b4.out_stddev});
    end
    vectors++;
    if ({busy1, done1, b1.in_ready, b1.out_valid, b1.out_last, b1.out_row, b1.out_avg, b1.out_stddev} !== '0) begin
      miscompares++;
      $display("FAIL reset_dut1: got %h expected 0", {busy1, done1, b1.in_ready, b1.out_valid, b1.out_last, b1.out_row, b1.out_avg, b1.out_stddev});
    end
  endtask

  task automatic test_single_row;
    int v[4] = '{2, 4, 4, 6};
    int i = 0, g = 0, k = 1;
    logic [EW-1:0] e;
    e = pack_exp(v, 0, 1'b1);
    @(negedge clk); start1 = 1'b1;
    @(negedge clk); start1 = 1'b0;
    b1.in_valid = 1'b1;
    while (i < N && g < 100) begin
      b1.in_data = WIDTH'(v[i]);
      #1;
      if (b1.in_ready) i++;
      g++;
      @(negedge clk);
    end
    b1.in_valid = 1'b0;
    while (b1.out_valid !== 1'b1 && k < 60) begin
      @(negedge clk);
      k++;
    end
    vectors++;
    if (k != 18) begin
      miscompares++;
      $display("FAIL latency: out_valid in cycle %0d after last accept, expected 18", k);
    end
    vectors++;
    if ({b1.out_avg, b1.out_stddev, b1.out_last, b1.out_row} !== {e[EW-1:3], 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL single_row: got avg %h sd %0d last %b row %b expected avg %h sd %0d last 1 row 0",
               b1.out_avg, b1.out_stddev, b1.out_last, b1.out_row, e[EW-1 -: RW], e[RW+2 -: RW]);
    end
    @(negedge clk);
    vectors++;
    if ({done1, busy1} !== 2'b10) begin
      miscompares++;
      $display("FAIL single_done: got done %b busy %b expected done 1 busy 0", done1, busy1);
    end
    @(negedge clk);
    vectors++;
    if (done1 !== 1'b0) begin
      miscompares++;
      $display("FAIL single_done_pulse: got %b expected 0", done1);
    end
  endtask

  task automatic test_frame;
    int rows[4][4] = '{'{7, 7, 7, 7}, '{1, 2, 3, 4}, '{0, 0, 255, 255}, '{2, 4, 4, 6}};
    int d0;
    bit ok;
    logic [EW-1:0] e;
    d0 = done_cnt4;
    b4.out_ready = 1'b1;
    pulse_start4();
    for (int r = 0; r < 4; r++) begin
      e = pack_exp(rows[r], r, r == 3);
      drive_row4(rows[r], 0, ok);
      wait_out4(ok);
      vectors++;
      if (!ok || {b4.out_avg, b4.out_stddev, b4.out_row, b4.out_last} !== e) begin
        miscompares++;
        $display("FAIL frame_row%0d: got %h expected %h", r, {b4.out_avg, b4.out_stddev, b4.out_row, b4.out_last}, e);
      end
      @(negedge clk);
    end
    @(negedge clk);
    vectors++;
    if (done_cnt4 - d0 != 1 || busy4 !== 1'b0) begin
      miscompares++;
      $display("FAIL frame_done: got %0d done pulses busy %b expected 1 and 0", done_cnt4 - d0, busy4);
    end
  endtask

  task automatic test_backpressure;
    int v[4];
    bit ok, bad;
    logic [EW-1:0] e;
    rand_row(v);
    e = pack_exp(v, 0, 1'b0);
    b4.out_ready = 1'b0;
    pulse_start4();
    drive_row4(v, 0, ok);
    wait_out4(ok);
    bad = !ok;
    for (int c = 0; c < 10; c++) begin
      vectors++;
      if (bad || b4.out_valid !== 1'b1 || b4.in_ready !== 1'b0 ||
          {b4.out_avg, b4.out_stddev, b4.out_row, b4.out_last} !== e) begin
        miscompares++;
        $display("FAIL backpressure_hold c%0d: got v%b r%b %h expected v1 r0 %h", c, b4.out_valid,
                 b4.in_ready, {b4.out_avg, b4.out_stddev, b4.out_row, b4.out_last}, e);
      end
      @(negedge clk);
    end
    b4.out_ready = 1'b1;
    @(negedge clk);
    vectors++;
    if ({b4.out_valid, b4.in_ready, b4.out_row} !== 4'b0101) begin
      miscompares++;
      $display("FAIL backpressure_release: got %b expected 0101", {b4.out_valid, b4.in_ready, b4.out_row});
    end
    for (int r = 1; r < 4; r++) begin
      rand_row(v);
      e = pack_exp(v, r, r == 3);
      drive_row4(v, 0, ok);
      wait_out4(ok);
      vectors++;
      if (!ok || {b4.out_avg, b4.out_stddev, b4.out_row, b4.out_last} !== e) begin
        miscompares++;
        $display("FAIL backpressure_row%0d: got %h expected %h", r, {b4.out_avg, b4.out_stddev, b4.out_row, b4.out_last}, e);
      end
      @(negedge clk);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_bubbles;
    int v[4] = '{1, 2, 3, 4};
    bit ok;
    logic [EW-1:0] e;
    pulse_start4();
    for (int r = 0; r < 4; r++) begin
      if (r > 0) rand_row(v);
      e = pack_exp(v, r, r == 3);
      drive_row4(v, 1, ok);
      wait_out4(ok);
      vectors++;
      if (!ok || {b4.out_avg, b4.out_stddev, b4.out_row, b4.out_last} !== e) begin
        miscompares++;
        $display("FAIL bubbles_row%0d: got %h expected %h", r, {b4.out_avg, b4.out_stddev, b4.out_row, b4.out_last}, e);
      end
      @(negedge clk);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_start_ignored;
    int v[4];
    int d0;
    bit ok;
    logic [EW-1:0] e;
    d0 = done_cnt4;
    pulse_start4();
    for (int r = 0; r < 4; r++) begin
      rand_row(v);
      e = pack_exp(v, r, r == 3);
      drive_row4(v, 0, ok);
      b4.out_ready = 1'b0;
      repeat (3) @(negedge clk);
      pulse_start4();
      wait_out4(ok);
      start4 = 1'b1;
      @(negedge clk);
      start4 = 1'b0;
      vectors++;
      if (!ok || {b4.out_avg, b4.out_stddev, b4.out_row, b4.out_last} !== e) begin
        miscompares++;
        $display("FAIL start_ignored_row%0d: got %h expected %h", r, {b4.out_avg, b4.out_stddev, b4.out_row, b4.out_last}, e);
      end
      b4.out_ready = 1'b1;
      @(negedge clk);
    end
    repeat (2) @(negedge clk);
    vectors++;
    if (done_cnt4 - d0 != 1 || busy4 !== 1'b0) begin
      miscompares++;
      $display("FAIL start_ignored_done: got %0d done pulses busy %b expected 1 and 0", done_cnt4 - d0, busy4);
    end
  endtask

  task automatic test_reset_mid_sqrt;
    int v[4];
    int seven[4] = '{7, 7, 7, 7};
    bit ok;
    logic [EW-1:0] e;
    pulse_start4();
    rand_row(v);
    drive_row4(v, 0, ok);
    wait_out4(ok);
    @(negedge clk);
    rand_row(v);
    drive_row4(v, 0, ok);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    vectors++;
    if ({busy4, done4, b4.in_ready, b4.out_valid, b4.out_last, b4.out_row, st4,
         b4.out_avg, b4.out_stddev} !== '0) begin
      miscompares++;
      $display("FAIL reset_mid_sqrt: got %h expected 0", {busy4, done4, b4.in_ready, b4.out_valid,
               b4.out_last, b4.out_row, st4, b4.out_avg, b4.out_stddev});
    end
    pulse_start4();
    for (int r = 0; r < 4; r++) begin
      if (r == 0) v = seven; else rand_row(v);
      e = pack_exp(v, r, r == 3);
      drive_row4(v, 0, ok);
      wait_out4(ok);
      vectors++;
      if (!ok || {b4.out_avg, b4.out_stddev, b4.out_row, b4.out_last} !== e) begin
        miscompares++;
        $display("FAIL after_reset_row%0d: got %h expected %h", r, {b4.out_avg, b4.out_stddev, b4.out_row, b4.out_last}, e);
      end
      @(negedge clk);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_random;
    int v[4];
    int d0;
    bit ok;
    logic [EW-1:0] e;
    for (int fr = 0; fr < 3; fr++) begin
      d0 = done_cnt4;
      pulse_start4();
      for (int r = 0; r < 4; r++) begin
        rand_row(v);
        exp_q.push_back(pack_exp(v, r, r == 3));
        drive_row4(v, 2, ok);
        b4.out_ready = 1'b0;
        wait_out4(ok);
        repeat ($urandom_range(0, 3)) @(negedge clk);
        e = exp_q.pop_front();
        vectors++;
        if (!ok || {b4.out_avg, b4.out_stddev, b4.out_row, b4.out_last} !== e) begin
          miscompares++;
          $display("FAIL random_f%0d_r%0d: got %h expected %h", fr, r, {b4.out_avg, b4.out_stddev, b4.out_row, b4.out_last}, e);
        end
        b4.out_ready = 1'b1;
        @(negedge clk);
      end
      @(negedge clk);
      vectors++;
      if (done_cnt4 - d0 != 1) begin
        miscompares++;
        $display("FAIL random_done_f%0d: got %0d pulses expected 1", fr, done_cnt4 - d0);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_row();
    test_frame();
    test_backpressure();
    test_bubbles();
    test_start_ignored();
    test_reset_mid_sqrt();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
